// File: rtl/ctrl_pipe_ic.sv
// Control-word pipeline with backup sweep and direct-restore port.
// Define CTRL_PIPE_IC_DIRTY_EN to track per-stage dirty flags and let sweeps skip clean stages.
module ctrl_pipe_ic #(
    parameter int STAGES = 3,
    parameter int W = 32,
    parameter logic [W-1:0] FLUSH_WORD = '0,
    localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [W-1:0]          Vin,
    input  logic                  stand_by,
    input  logic                  Flush,
    input  logic                  Pwr_off,
    output logic [STAGES*W-1:0]   Vout,
    output logic [STAGES-1:0]     Dirty,
    input  logic                  Backup_req,
    output logic                  Backup_valid,
    output logic [IW-1:0]         Backup_idx,
    output logic [W-1:0]          Backup_Vout,
    input  logic                  Backup_ack,
    output logic                  Backup_busy,
    output logic                  Backup_done,
    input  logic                  Restore_en,
    input  logic [IW-1:0]         Restore_idx,
    input  logic [W-1:0]          Restore_Vin
);

    // state    | meaning
    // IDLE     | no sweep; shift, flush and restore allowed
    // SCAN     | inspecting stage at ptr_q, one cycle per stage
    // WAIT_ACK | presenting stage ptr_q until Backup_ack
    // DONE     | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, SCAN, WAIT_ACK, DONE} state_t;

    localparam logic [IW-1:0] LAST = IW'(STAGES - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [W-1:0]  stage_q [STAGES];
    logic [W-1:0]  stage_d [STAGES];
    logic          flush_pend_q, flush_pend_d;
    logic          busy, do_flush, do_restore, shift_en, ack_take, scan_hit;

    assign busy       = (state_q != IDLE);
    // A flush seen mid-sweep waits in flush_pend_q so swept words stay coherent.
    assign do_flush   = !Pwr_off && !busy && (Flush || flush_pend_q);
    assign do_restore = !Pwr_off && !busy && !do_flush && Restore_en
                        && (int'(Restore_idx) < STAGES);
    assign shift_en   = !Pwr_off && !busy && !stand_by && !Restore_en && !Flush && !do_flush;
    assign ack_take   = (state_q == WAIT_ACK) && Backup_ack;

    always_comb begin
        stage_d = stage_q;
        if (Pwr_off) begin
            for (int k = 0; k < STAGES; k++) stage_d[k] = '0;
        end else if (do_flush) begin
            for (int k = 0; k < STAGES; k++) stage_d[k] = FLUSH_WORD;
        end else if (do_restore) begin
            stage_d[Restore_idx] = Restore_Vin;
        end else if (shift_en) begin
            stage_d[0] = Vin;
            for (int k = 1; k < STAGES; k++) stage_d[k] = stage_q[k-1];
        end
    end

    always_comb begin
        flush_pend_d = flush_pend_q;
        if (Pwr_off)            flush_pend_d = 1'b0;
        else if (busy && Flush) flush_pend_d = 1'b1;
        else if (!busy)         flush_pend_d = 1'b0;
    end

`ifdef CTRL_PIPE_IC_DIRTY_EN
    logic [STAGES-1:0] dirty_q, dirty_d;

    always_comb begin
        dirty_d = dirty_q;
        if (Pwr_off) begin
            dirty_d = '0;
        end else begin
            if (do_flush || shift_en) begin
                for (int k = 0; k < STAGES; k++)
                    if (stage_d[k] != stage_q[k]) dirty_d[k] = 1'b1;
            end
            if (do_restore) dirty_d[Restore_idx] = 1'b0;
            if (ack_take)   dirty_d[ptr_q] = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) dirty_q <= '0;
        else      dirty_q <= dirty_d;
    end

    assign Dirty    = dirty_q;
    assign scan_hit = dirty_q[ptr_q];
`else
    assign Dirty    = '0;
    assign scan_hit = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (Pwr_off) begin
            state_d = IDLE;
            ptr_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (Backup_req) begin
                    state_d = SCAN;
                    ptr_d   = '0;
                end
                SCAN: begin
                    if (scan_hit)            state_d = WAIT_ACK;
                    else if (ptr_q == LAST)  state_d = DONE;
                    else                     ptr_d   = ptr_q + 1'b1;
                end
                WAIT_ACK: if (Backup_ack) begin
                    if (ptr_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = SCAN;
                        ptr_d   = ptr_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            flush_pend_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            flush_pend_q <= flush_pend_d;
            for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
        end
    end

    always_comb begin
        Vout = '0;
        for (int k = 0; k < STAGES; k++) Vout[k*W +: W] = stage_q[k];
    end

    assign Backup_valid = (state_q == WAIT_ACK);
    assign Backup_idx   = Backup_valid ? ptr_q : '0;
    assign Backup_Vout  = Backup_valid ? stage_q[ptr_q] : '0;
    assign Backup_busy  = busy;
    assign Backup_done  = (state_q == DONE);

endmodule

// File: tb/tb_ctrl_pipe_ic.sv
// Directed bench for ctrl_pipe_ic (STAGES=3, W=32); expectations follow CTRL_PIPE_IC_DIRTY_EN when defined.
module tb_ctrl_pipe_ic;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] Vin;
    logic        stand_by, Flush, Pwr_off;
    logic [95:0] Vout;
    logic [2:0]  Dirty;
    logic        Backup_req, Backup_valid, Backup_ack, Backup_busy, Backup_done;
    logic [1:0]  Backup_idx;
    logic [31:0] Backup_Vout;
    logic        Restore_en;
    logic [1:0]  Restore_idx;
    logic [31:0] Restore_Vin;

    int n_cmp = 0;
    int n_fail = 0;

    int          busy_cnt, done_cnt, nvalid;
    logic [1:0]  seen_idx [8];
    logic [31:0] seen_word [8];

    ctrl_pipe_ic #(.STAGES(3), .W(32)) dut (
        .Clk(Clk), .Rst(Rst), .Vin(Vin), .stand_by(stand_by), .Flush(Flush),
        .Pwr_off(Pwr_off), .Vout(Vout), .Dirty(Dirty), .Backup_req(Backup_req),
        .Backup_valid(Backup_valid), .Backup_idx(Backup_idx), .Backup_Vout(Backup_Vout),
        .Backup_ack(Backup_ack), .Backup_busy(Backup_busy), .Backup_done(Backup_done),
        .Restore_en(Restore_en), .Restore_idx(Restore_idx), .Restore_Vin(Restore_Vin)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!Backup_valid && n < 8) begin
            @(negedge Clk);
            n++;
        end
        chk("wait_valid", 128'(Backup_valid), 128'(1'b1));
    endtask

    // Runs one full sweep, acking every presented word immediately.
    task automatic run_sweep();
        busy_cnt = 0;
        done_cnt = 0;
        nvalid   = 0;
        Backup_req = 1'b1;
        @(negedge Clk);
        Backup_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!Backup_busy) break;
            busy_cnt++;
            if (Backup_done) done_cnt++;
            if (Backup_valid) begin
                if (nvalid < 8) begin
                    seen_idx[nvalid]  = Backup_idx;
                    seen_word[nvalid] = Backup_Vout;
                end
                nvalid++;
                Backup_ack = 1'b1;
            end else begin
                Backup_ack = 1'b0;
            end
            @(negedge Clk);
        end
        Backup_ack = 1'b0;
        chk("sweep_ends", 128'(Backup_busy), 128'(1'b0));
    endtask

    initial begin
        Rst = 1'b0; Vin = '0; stand_by = 1'b0; Flush = 1'b0; Pwr_off = 1'b0;
        Backup_req = 1'b0; Backup_ack = 1'b0;
        Restore_en = 1'b0; Restore_idx = '0; Restore_Vin = '0;

        #3;
        chk("rst_vout", 128'(Vout), 128'(0));
        chk("rst_dirty", 128'(Dirty), 128'(0));
        chk("rst_busy", 128'(Backup_busy), 128'(0));
        chk("rst_valid", 128'(Backup_valid), 128'(0));
        chk("rst_done", 128'(Backup_done), 128'(0));
        chk("rst_idx", 128'(Backup_idx), 128'(0));
        chk("rst_bvout", 128'(Backup_Vout), 128'(0));
        #9 Rst = 1'b1;
        @(negedge Clk);
        chk("release_done", 128'(Backup_done), 128'(0));

        // shift three words in
        Vin = 32'h11; @(negedge Clk);
        Vin = 32'h22; @(negedge Clk);
        Vin = 32'h33; @(negedge Clk);
        stand_by = 1'b1;
        chk("shift3_vout", 128'(Vout), 128'({32'h11, 32'h22, 32'h33}));
`ifdef CTRL_PIPE_IC_DIRTY_EN
        chk("shift3_dirty", 128'(Dirty), 128'(3'b111));
`else
        chk("shift3_dirty", 128'(Dirty), 128'(3'b000));
`endif
        Vin = 32'h44; @(negedge Clk);
        chk("standby_hold", 128'(Vout), 128'({32'h11, 32'h22, 32'h33}));

        // sweep with held-off ack, stand_by low, and a flush that must wait
        Vin = 32'h99;
        Backup_req = 1'b1; @(negedge Clk);
        Backup_req = 1'b0; stand_by = 1'b0;
        wait_valid();
        for (int i = 0; i < 4; i++) begin
            chk("hold_idx", 128'(Backup_idx), 128'(2'd0));
            chk("hold_word", 128'(Backup_Vout), 128'(32'h33));
            chk("hold_noshift", 128'(Vout), 128'({32'h11, 32'h22, 32'h33}));
            Flush = (i == 1);
            @(negedge Clk);
        end
        Flush = 1'b0;
        chk("flush_deferred", 128'(Vout), 128'({32'h11, 32'h22, 32'h33}));
        Backup_ack = 1'b1; @(negedge Clk); Backup_ack = 1'b0;
        wait_valid();
        chk("sw1_idx1", 128'(Backup_idx), 128'(2'd1));
        chk("sw1_word1", 128'(Backup_Vout), 128'(32'h22));
        Backup_ack = 1'b1; @(negedge Clk); Backup_ack = 1'b0;
        wait_valid();
        chk("sw1_idx2", 128'(Backup_idx), 128'(2'd2));
        chk("sw1_word2", 128'(Backup_Vout), 128'(32'h11));
        Backup_ack = 1'b1; @(negedge Clk); Backup_ack = 1'b0;
        stand_by = 1'b1;
        chk("sw1_done", 128'(Backup_done), 128'(1'b1));
        chk("sw1_dirty", 128'(Dirty), 128'(3'b000));
        @(negedge Clk);
        chk("sw1_done_pulse", 128'(Backup_done), 128'(1'b0));
        chk("sw1_idle", 128'(Backup_busy), 128'(1'b0));
        chk("sw1_pre_flush", 128'(Vout), 128'({32'h11, 32'h22, 32'h33}));
        @(negedge Clk);
        chk("flush_applied", 128'(Vout), 128'(0));
`ifdef CTRL_PIPE_IC_DIRTY_EN
        chk("flush_dirty", 128'(Dirty), 128'(3'b111));
`else
        chk("flush_dirty", 128'(Dirty), 128'(3'b000));
`endif

        // restores
        Restore_en = 1'b1; Restore_idx = 2'd0; Restore_Vin = 32'hA0; @(negedge Clk);
        chk("rest0_vout", 128'(Vout), 128'({32'h0, 32'h0, 32'hA0}));
        Restore_idx = 2'd2; Restore_Vin = 32'hC2; @(negedge Clk);
        chk("rest2_vout", 128'(Vout), 128'({32'hC2, 32'h0, 32'hA0}));
        stand_by = 1'b0; Vin = 32'h55;
        Restore_idx = 2'd2; Restore_Vin = 32'hDEADBEEF; @(negedge Clk);
        chk("rest_vs_shift", 128'(Vout), 128'({32'hDEADBEEF, 32'h0, 32'hA0}));
        Restore_idx = 2'd3; Restore_Vin = 32'hFFFF; @(negedge Clk);
        chk("rest_idx_oob", 128'(Vout), 128'({32'hDEADBEEF, 32'h0, 32'hA0}));
`ifdef CTRL_PIPE_IC_DIRTY_EN
        chk("rest_dirty", 128'(Dirty), 128'(3'b010));
`else
        chk("rest_dirty", 128'(Dirty), 128'(3'b000));
`endif
        stand_by = 1'b1;

        // sweep while a restore is attempted; restore must be ignored
        Restore_idx = 2'd0; Restore_Vin = 32'hBAD;
        Restore_en = 1'b0;
        Backup_req = 1'b1; @(negedge Clk);
        Backup_req = 1'b0; Restore_en = 1'b1;
        busy_cnt = 1; done_cnt = 0; nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            if (!Backup_busy) break;
            if (i > 0) busy_cnt++;
            if (Backup_done) done_cnt++;
            if (Backup_valid) begin
                if (nvalid < 8) begin
                    seen_idx[nvalid]  = Backup_idx;
                    seen_word[nvalid] = Backup_Vout;
                end
                nvalid++;
                Backup_ack = 1'b1;
            end else begin
                Backup_ack = 1'b0;
            end
            @(negedge Clk);
        end
        Backup_ack = 1'b0; Restore_en = 1'b0;
        chk("sw2_ends", 128'(Backup_busy), 128'(1'b0));
        chk("sw2_done_cnt", 128'(done_cnt), 128'(1));
        chk("sw2_no_restore", 128'(Vout), 128'({32'hDEADBEEF, 32'h0, 32'hA0}));
        chk("sw2_dirty", 128'(Dirty), 128'(3'b000));
`ifdef CTRL_PIPE_IC_DIRTY_EN
        chk("sw2_len", 128'(busy_cnt), 128'(5));
        chk("sw2_nvalid", 128'(nvalid), 128'(1));
        chk("sw2_idx", 128'(seen_idx[0]), 128'(2'd1));
        chk("sw2_word", 128'(seen_word[0]), 128'(32'h0));
`else
        chk("sw2_len", 128'(busy_cnt), 128'(7));
        chk("sw2_nvalid", 128'(nvalid), 128'(3));
        chk("sw2_idx0", 128'(seen_idx[0]), 128'(2'd0));
        chk("sw2_idx1", 128'(seen_idx[1]), 128'(2'd1));
        chk("sw2_idx2", 128'(seen_idx[2]), 128'(2'd2));
        chk("sw2_word0", 128'(seen_word[0]), 128'(32'hA0));
        chk("sw2_word2", 128'(seen_word[2]), 128'(32'hDEADBEEF));
`endif

        // Pwr_off while waiting for ack
        stand_by = 1'b0; Vin = 32'h77; @(negedge Clk);
        stand_by = 1'b1;
        chk("shift_after_sweep", 128'(Vout), 128'({32'h0, 32'hA0, 32'h77}));
        Backup_req = 1'b1; @(negedge Clk); Backup_req = 1'b0;
        wait_valid();
        chk("pwr_pre_idx", 128'(Backup_idx), 128'(2'd0));
        Pwr_off = 1'b1; @(negedge Clk); Pwr_off = 1'b0;
        chk("pwr_vout", 128'(Vout), 128'(0));
        chk("pwr_busy", 128'(Backup_busy), 128'(0));
        chk("pwr_valid", 128'(Backup_valid), 128'(0));
        chk("pwr_done", 128'(Backup_done), 128'(0));
        chk("pwr_dirty", 128'(Dirty), 128'(0));
        @(negedge Clk);
        chk("pwr_done_later", 128'(Backup_done), 128'(0));

        // async reset mid-sweep
        stand_by = 1'b0;
        Vin = 32'h1; @(negedge Clk);
        Vin = 32'h2; @(negedge Clk);
        Vin = 32'h3; @(negedge Clk);
        stand_by = 1'b1;
        chk("pre_rst_vout", 128'(Vout), 128'({32'h1, 32'h2, 32'h3}));
        Backup_req = 1'b1; @(negedge Clk); Backup_req = 1'b0;
        wait_valid();
        #2 Rst = 1'b0;
        #1;
        chk("arst_vout", 128'(Vout), 128'(0));
        chk("arst_busy", 128'(Backup_busy), 128'(0));
        chk("arst_valid", 128'(Backup_valid), 128'(0));
        chk("arst_idx", 128'(Backup_idx), 128'(0));
        chk("arst_bvout", 128'(Backup_Vout), 128'(0));
        chk("arst_dirty", 128'(Dirty), 128'(0));
        #4 Rst = 1'b1;
        @(negedge Clk);
        chk("arst_rel_done", 128'(Backup_done), 128'(0));
        run_sweep();
        chk("sw3_done_cnt", 128'(done_cnt), 128'(1));
`ifdef CTRL_PIPE_IC_DIRTY_EN
        chk("sw3_len", 128'(busy_cnt), 128'(4));
        chk("sw3_nvalid", 128'(nvalid), 128'(0));
`else
        chk("sw3_len", 128'(busy_cnt), 128'(7));
        chk("sw3_nvalid", 128'(nvalid), 128'(3));
        chk("sw3_idx0", 128'(seen_idx[0]), 128'(2'd0));
        chk("sw3_idx1", 128'(seen_idx[1]), 128'(2'd1));
        chk("sw3_idx2", 128'(seen_idx[2]), 128'(2'd2));
        chk("sw3_word1", 128'(seen_word[1]), 128'(32'h0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_ic.md
CTRL_PIPE_IC -- requirements
Module: ctrl_pipe_ic

Interface
REQ-001 SHALL have parameter STAGES, default 3: number of pipeline stages, range 1..16.
REQ-002 SHALL have parameter W, default 32: width of each stage control word.
REQ-003 SHALL have parameter FLUSH_WORD, default all-zero W-bit value: word loaded into stages on flush.
REQ-004 SHALL define IW = max(1, clog2(STAGES)) as the stage-index width.
REQ-005 Clk  in  1  single clock; all state changes on the rising edge.
REQ-006 Rst  in  1  asynchronous, active-low reset.
REQ-007 Vin  in  W  control word entering stage 0.
REQ-008 stand_by  in  1  freezes pipeline shifting while high.
REQ-009 Flush  in  1  synchronously loads FLUSH_WORD into all stages.
REQ-010 Pwr_off  in  1  synchronous volatile-state loss.
REQ-011 Vout  out  STAGES*W  stage contents; stage k occupies bits [k*W+W-1 : k*W].
REQ-012 Dirty  out  STAGES  per-stage dirty flags.
REQ-013 Backup_req  in  1  single-cycle pulse that starts a backup sweep.
REQ-014 Backup_valid, Backup_idx, Backup_Vout  out  1, IW, W  presented stage word.
REQ-015 Backup_ack  in  1  accepts the presented word.
REQ-016 Backup_busy, Backup_done  out  1, 1  sweep in progress; single-cycle completion pulse.
REQ-017 Restore_en, Restore_idx, Restore_Vin  in  1, IW, W  direct write of one stage.

Function
REQ-018 Shift rule: when enabled, stage 0 SHALL load Vin and stage k SHALL load stage k-1, for k = 1..STAGES-1.
REQ-019 Shifting SHALL be enabled only when stand_by=0, Backup_busy=0, Restore_en=0 and Flush=0.
REQ-020 Priority SHALL be, highest first: Rst, Pwr_off, Flush, Restore, backup sweep, shift.
REQ-021 Dirty[k] SHALL set on any shift or flush that changes the value held in stage k.
REQ-022 Dirty[k] SHALL clear when stage k is restored, when its backup is acked, or on Pwr_off.
REQ-023 Restore SHALL write Restore_Vin into stage Restore_idx in one cycle; an index >= STAGES SHALL be ignored.
REQ-024 Restore SHALL be ignored while Backup_busy=1.
REQ-025 The FSM SHALL have states IDLE, SCAN, WAIT_ACK and DONE.
REQ-026 IDLE->SCAN on Backup_req; the scan pointer SHALL start at 0.
REQ-027 SCAN, clean stage: the pointer SHALL advance with one cycle per stage.
REQ-028 SCAN, dirty stage: the FSM SHALL go to WAIT_ACK.
REQ-029 In WAIT_ACK, Backup_valid=1, Backup_idx=pointer and Backup_Vout=stage word, all held stable until Backup_ack.
REQ-030 On ack, the FSM SHALL clear that dirty flag and return to SCAN at pointer+1.
REQ-031 After stage STAGES-1 the FSM SHALL go to DONE; DONE SHALL assert Backup_done for one cycle, then go to IDLE.
REQ-032 Backup_busy SHALL be 1 in SCAN, WAIT_ACK and DONE.
REQ-033 Backup_req while busy SHALL be ignored.
REQ-034 Backup_ack outside WAIT_ACK SHALL be ignored.
REQ-035 Pwr_off SHALL clear all stages, dirty flags and the pointer, and force IDLE.
REQ-036 An in-flight sweep aborted by Pwr_off SHALL NOT pulse Backup_done.
REQ-037 Flush during a sweep SHALL be deferred until IDLE, so that swept words stay coherent.

Reset
REQ-038 Rst=0 SHALL asynchronously force: all stages 0, Dirty 0, FSM IDLE, pointer 0.
REQ-039 Rst=0 SHALL also force: Backup_valid, Backup_busy and Backup_done 0; Backup_idx 0; Backup_Vout 0.
REQ-040 Reset release SHALL take effect at the next rising Clk edge, with no spurious Backup_done.

Configuration
REQ-041 Macro CTRL_PIPE_IC_DIRTY_EN defined: dirty tracking SHALL behave as above, and SCAN SHALL skip clean stages.
REQ-042 Macro undefined: Dirty SHALL be tied 0, and every sweep SHALL present all STAGES stages in index order regardless of content.

Verification
REQ-043 STAGES=3, W=32: shift 0x11, 0x22, 0x33 -> Vout = {0x11, 0x22, 0x33} with stage2=0x11; Dirty=3'b111.
REQ-044 With DIRTY_EN, only stage1 dirty, Backup_req -> exactly one Backup_valid with idx=1; ack -> Backup_done 1 cycle later; Dirty=0; sweep length 5 cycles.
REQ-045 Ack held off 4 cycles -> Backup_Vout/idx stable throughout; stand_by=0 yet pipeline does not shift during the sweep.
REQ-046 Restore idx=2, Vin=0xDEADBEEF concurrent with shift -> stage2=0xDEADBEEF, no shift that cycle, Dirty[2]=0.
REQ-047 Pwr_off asserted in WAIT_ACK -> next cycle all stages 0, IDLE, Backup_busy=0, no Backup_done pulse.
REQ-048 Rst low mid-sweep, asynchronous to Clk -> outputs zero immediately; without DIRTY_EN, a sweep after release presents idx 0, 1, 2.
